sap1_controller: RTL

- Instruction register plus controller-sequencer for the SAP-1 datapath; sits directly downstream of the 16x8 ram and consumes its data_out during instruction fetch.
- Holds the fetched instruction, drives the operand nibble back onto the bus, and steps a six-state ring counter (T1..T6).
- Emits every datapath control line: pc, MAR, ram, A, B, ALU and output register.
- Supports LDA, ADD, SUB, OUT and HLT; all other opcodes execute as NOP.

---
 rtl/sap1_controller.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sap1_controller.sv
// SAP-1 instruction register and six-state ring-counter sequencer.
// Decodes LDA/ADD/SUB/OUT/HLT into the datapath's bus and load controls.
module sap1_controller #(
  parameter int          DATA_WIDTH = 8,
  parameter int          ADDR_WIDTH = 4,
  parameter logic [3:0]  OP_LDA     = 4'h0,
  parameter logic [3:0]  OP_ADD     = 4'h1,
  parameter logic [3:0]  OP_SUB     = 4'h2,
  parameter logic [3:0]  OP_OUT     = 4'hE,
  parameter logic [3:0]  OP_HLT     = 4'hF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ir_in,
  output logic [ADDR_WIDTH-1:0] ir_out,
  output logic [3:0]            opcode,
  output logic [5:0]            t_state,
  output logic                  pc_inc,
  output logic                  pc_en,
  output logic                  mar_load,
  output logic                  ram_en,
  output logic                  ir_load,
  output logic                  ir_en,
  output logic                  a_load,
  output logic                  a_en,
  output logic                  b_load,
  output logic                  alu_en,
  output logic                  alu_sub,
  output logic                  out_load,
  output logic                  halted
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  tstate_e               t_q, t_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic                  halt_q, halt_d;

  assign opcode  = ir_q[DATA_WIDTH-1 -: 4];
  assign ir_out  = ir_q[ADDR_WIDTH-1:0];
  assign t_state = t_q;

  // A HLT parks the counter in T4 instead of stepping on to T5.
  always_comb begin
    t_d    = t_q;
    ir_d   = ir_q;
    halt_d = halt_q;
    if (!halt_q) begin
      case (t_q)
        T1: t_d = T2;
        T2: t_d = T3;
        T3: begin
          t_d  = T4;
          ir_d = ir_in;
        end
        T4: begin
          if (opcode == OP_HLT) halt_d = 1'b1;
          else                  t_d    = T5;
        end
        T5: t_d = T6;
        default: t_d = T1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q    <= T1;
      ir_q   <= '0;
      halt_q <= 1'b0;
    end else begin
      t_q    <= t_d;
      ir_q   <= ir_d;
      halt_q <= halt_d;
    end
  end

  // Controls are gated by rst so nothing pulses while reset is asserted.
  always_comb begin
    pc_inc   = 1'b0;
    pc_en    = 1'b0;
    mar_load = 1'b0;
    ram_en   = 1'b0;
    ir_load  = 1'b0;
    ir_en    = 1'b0;
    a_load   = 1'b0;
    a_en     = 1'b0;
    b_load   = 1'b0;
    alu_en   = 1'b0;
    alu_sub  = 1'b0;
    out_load = 1'b0;
    if (!rst && !halt_q) begin
      case (t_q)
        T1: begin
          pc_en    = 1'b1;
          mar_load = 1'b1;
        end
        T2: pc_inc = 1'b1;
        T3: begin
          ram_en  = 1'b1;
          ir_load = 1'b1;
        end
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            ir_en    = 1'b1;
            mar_load = 1'b1;
          end else if (opcode == OP_OUT) begin
            a_en     = 1'b1;
            out_load = 1'b1;
          end
        end
        T5: begin
          if (opcode == OP_LDA) begin
            ram_en = 1'b1;
            a_load = 1'b1;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            ram_en = 1'b1;
            b_load = 1'b1;
          end
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_en  = 1'b1;
            a_load  = 1'b1;
            alu_sub = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign halted = halt_q | (!rst && (t_q == T4) && (opcode == OP_HLT));

endmodule
